// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: synchronizes the serial line, recovers each byte
// and reports it with a one-cycle valid pulse or a one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLK_FREQ_KHz  = 50000,
    parameter int BAUD_RATE_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_en,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int BIT_CLOCKS = (CLK_FREQ_KHz * 1000) / BAUD_RATE_BPS;
    localparam int CW         = $clog2(BIT_CLOCKS);

    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLOCKS / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLOCKS - 1);

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        START_BIT = 5'b00010,
        DATA_BITS = 5'b00100,
        STOP_BIT  = 5'b01000,
        FINALIZE  = 5'b10000
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]    data_cnt, data_cnt_n;
    logic [7:0]    shift, shift_n;
    logic [7:0]    data_n;
    logic          data_en_n, frame_err_n;
    logic          rx_meta, rx_s;

    // NOTE: async active-low reset; the synchronizer resets to 1 so a reset
    // release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        data_cnt_n  = data_cnt;
        shift_n     = shift;
        data_n      = data;
        data_en_n   = 1'b0;
        frame_err_n = 1'b0;
        unique case (state)
            IDLE: begin
                bit_cnt_n  = '0;
                data_cnt_n = '0;
                if (!rx_s) state_n = START_BIT;
            end
            START_BIT: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = rx_s ? IDLE : DATA_BITS;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            DATA_BITS: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    if (data_cnt == 3'd7) begin
                        data_cnt_n = '0;
                        state_n    = STOP_BIT;
                    end else begin
                        data_cnt_n = data_cnt + 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            STOP_BIT: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    state_n   = FINALIZE;
                    if (rx_s) begin
                        data_n    = shift;
                        data_en_n = 1'b1;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            FINALIZE: begin
                // A break (line still low) holds here so it cannot start a frame.
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_cnt  <= '0;
            shift     <= '0;
            data      <= '0;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            data_cnt  <= data_cnt_n;
            shift     <= shift_n;
            data      <= data_n;
            data_en   <= data_en_n;
            frame_err <= frame_err_n;
            rx_busy   <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: good frames, back-to-back,
// glitch, framing error with break, mid-frame reset and a random byte stream.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       data_en;
    logic       rx_busy;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] dq[$];
    int         en_cnt   = 0;
    int         fe_cnt   = 0;
    int         both_cnt = 0;

    uart_rx #(.CLK_FREQ_KHz(1000), .BAUD_RATE_BPS(125000)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .data_en(data_en), .rx_busy(rx_busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst) begin
            if (data_en) begin
                dq.push_back(data);
                en_cnt++;
            end
            if (frame_err) fe_cnt++;
            if (data_en && frame_err) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] expq[$];
        logic [7:0] b;
        int en0, fe0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_data_en", data_en, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", rx_busy, 1'b0);
        rst = 1'b1;
        idle(5);

        // 1: single frame 0xA5
        send_frame(8'hA5, 1'b1);
        idle(16);
        check("t1_count", en_cnt, 1);
        check("t1_byte", dq.size() > 0 ? dq[0] : 8'hxx, 8'hA5);
        check("t1_data", data, 8'hA5);
        check("t1_no_ferr", fe_cnt, 0);
        check("t1_idle_busy", rx_busy, 1'b0);
        dq.delete();

        // 2: back-to-back 0x00, 0xFF with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(16);
        check("t2_count", en_cnt, 3);
        check("t2_byte0", dq.size() > 0 ? dq[0] : 8'hxx, 8'h00);
        check("t2_byte1", dq.size() > 1 ? dq[1] : 8'hxx, 8'hFF);
        dq.delete();

        // 3: 3-clock low glitch is rejected, then 0x3C
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (1) @(posedge clk);
        #1;
        check("t3_busy_during", rx_busy, 1'b1);
        idle(10);
        check("t3_busy_after", rx_busy, 1'b0);
        check("t3_no_pulse", en_cnt, 3);
        send_frame(8'h3C, 1'b1);
        idle(16);
        check("t3_count", en_cnt, 4);
        check("t3_byte", dq.size() > 0 ? dq[0] : 8'hxx, 8'h3C);
        dq.delete();

        // 4: stop bit low, line held low (break) for 40 clocks
        send_frame(8'h55, 1'b0);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t4_ferr_once", fe_cnt, 1);
        check("t4_no_data_en", en_cnt, 4);
        check("t4_data_kept", data, 8'h3C);
        check("t4_busy_break", rx_busy, 1'b1);
        idle(20);
        check("t4_busy_release", rx_busy, 1'b0);
        check("t4_no_new_frame", en_cnt, 4);
        check("t4_ferr_total", fe_cnt, 1);

        // 5: reset during data bit 4 of 0xF0, then 0x81
        en0 = en_cnt;
        fe0 = fe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_busy_pre", rx_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_busy", rx_busy, 1'b0);
        check("t5_rst_data", data, 8'h00);
        check("t5_rst_data_en", data_en, 1'b0);
        check("t5_rst_ferr", frame_err, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(20);
        check("t5_no_pulse_en", en_cnt, en0);
        check("t5_no_pulse_fe", fe_cnt, fe0);
        send_frame(8'h81, 1'b1);
        idle(16);
        check("t5_count", en_cnt, en0 + 1);
        check("t5_byte", dq.size() > 0 ? dq[0] : 8'hxx, 8'h81);
        dq.delete();

        // 6: 16 random bytes back-to-back, as a transmitter would send them
        en0 = en_cnt;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom_range(0, 255));
            expq.push_back(b);
            send_frame(b, 1'b1);
        end
        idle(20);
        check("t6_count", en_cnt - en0, 16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t6_byte%0d", i), dq.size() > i ? dq[i] : 8'hxx, expq[i]);

        check("never_both", both_cnt, 0);
        check("ferr_final", fe_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
